alu_reg_ctrl: RTL and testbench

- Operand/write-back controller wrapped around the 16-bit add/sub ALU.
- Accepts register-to-register instructions over a valid/ready handshake and holds an internal register bank.
- Drives the ALU operands and operation registered, then captures the ALU result and writes it back to the bank.
- Also supports a load-immediate path and a debug read port.

---
 rtl/alu_reg_ctrl_if.sv | 36 +++
 rtl/alu_reg_ctrl.sv | 88 ++++++++
 tb/tb_alu_reg_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_reg_ctrl_if.sv
// Instruction, ALU and write-back bus between the operand controller and its neighbours.
// The controller uses the slave modport; the instruction source and ALU use master.
interface alu_reg_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic             in_ld;
  logic             in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_ra;
  logic [AW-1:0]    in_rb;
  logic [WIDTH-1:0] in_imm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic [WIDTH-1:0] s;
  logic             out_valid;
  logic [AW-1:0]    out_rd;
  logic [WIDTH-1:0] out_data;
  logic             z;
  logic             n;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport slave (
    input  in_valid, in_ld, in_op, in_rd, in_ra, in_rb, in_imm, s, dbg_addr,
    output in_ready, a, b, op, out_valid, out_rd, out_data, z, n, dbg_data
  );

  modport master (
    output in_valid, in_ld, in_op, in_rd, in_ra, in_rb, in_imm, s, dbg_addr,
    input  in_ready, a, b, op, out_valid, out_rd, out_data, z, n, dbg_data
  );
endinterface

// File: rtl/alu_reg_ctrl.sv
// Operand fetch / write-back controller around a combinational add/sub ALU.
// Loads retire in one cycle; ALU ops spend one EXEC cycle while the ALU settles.
module alu_reg_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input logic           clk,
  input logic           rst_n,
  alu_reg_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [NREGS-1:0][WIDTH-1:0] bank;
  logic [AW-1:0]               rd_q;
  logic                        take;
  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [WIDTH-1:0]            wr_data;

  assign take = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take && !bus.in_ld) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
  end

  // Single write port: EXEC retires the ALU result, IDLE may retire a load.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.in_rd;
    wr_data = bus.in_imm;
    if (state == EXEC) begin
      wr_en   = 1'b1;
      wr_addr = rd_q;
      wr_data = bus.s;
    end else if (take && bus.in_ld) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank          <= '0;
      rd_q          <= '0;
      bus.a         <= '0;
      bus.b         <= '0;
      bus.op        <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_rd    <= '0;
      bus.out_data  <= '0;
      bus.z         <= 1'b0;
      bus.n         <= 1'b0;
    end else begin
      bus.out_valid <= wr_en;
      if (wr_en) begin
        bank[wr_addr] <= wr_data;
        bus.out_rd    <= wr_addr;
        bus.out_data  <= wr_data;
        bus.z         <= (wr_data == '0);
        bus.n         <= wr_data[WIDTH-1];
      end
      if (state == IDLE && take && !bus.in_ld) begin
        bus.a  <= bank[bus.in_ra];
        bus.b  <= bank[bus.in_rb];
        bus.op <= bus.in_op;
        rd_q   <= bus.in_rd;
      end
    end
  end

  // Debug read sees committed state only; no bypass of an in-flight write.
  assign bus.dbg_data = bank[bus.dbg_addr];
endmodule

// File: tb/tb_alu_reg_ctrl.sv
// Self-checking bench: directed scenarios plus random instruction stream
// compared against an array-based register-file model.
module tb_alu_reg_ctrl;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  typedef struct {
    bit             ld;
    bit             op;
    bit [AW-1:0]    rd, ra, rb;
    bit [WIDTH-1:0] imm;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  bit [WIDTH-1:0] mreg [8];
  bit [WIDTH-1:0] lastv = '0;
  bit             lastw = 1'b0;

  alu_reg_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_reg_ctrl #(.WIDTH(WIDTH), .NREGS(8), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // External add/sub ALU
  assign bus.s = bus.op ? bus.a + bus.b : bus.a - bus.b;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(bit ld, bit op, int rd, int ra, int rb, int imm);
    ins_t i;
    i.ld = ld; i.op = op; i.rd = rd[AW-1:0]; i.ra = ra[AW-1:0]; i.rb = rb[AW-1:0];
    i.imm = imm[WIDTH-1:0];
    return i;
  endfunction

  task automatic drive(input ins_t i);
    bus.in_valid = 1'b1;
    bus.in_ld    = i.ld;
    bus.in_op    = i.op;
    bus.in_rd    = i.rd;
    bus.in_ra    = i.ra;
    bus.in_rb    = i.rb;
    bus.in_imm   = i.imm;
  endtask

  task automatic chk_wb(input string tag, input bit [AW-1:0] rd, input bit [WIDTH-1:0] v);
    chk({tag, "_vld"},  bus.out_valid, 1);
    chk({tag, "_rd"},   bus.out_rd, rd);
    chk({tag, "_data"}, bus.out_data, v);
    chk({tag, "_z"},    bus.z, (v == 0));
    chk({tag, "_n"},    bus.n, v[WIDTH-1]);
  endtask

  task automatic chk_dbg(input string tag, input bit [AW-1:0] r);
    bus.dbg_addr = r;
    #1;
    chk(tag, bus.dbg_data, mreg[r]);
  endtask

  // Called just after a negedge. With pre=1 on an ALU op, nx is presented during EXEC.
  task automatic send(input string tag, input ins_t i, input bit pre, input ins_t nx);
    int w = 0;
    bit [WIDTH-1:0] va, vb, res;
    drive(i);
    while (!bus.in_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (w >= 8) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    if (i.ld) begin
      mreg[i.rd] = i.imm;
      chk_wb({tag, "_ld"}, i.rd, i.imm);
      chk({tag, "_ld_rdy"}, bus.in_ready, 1);
      lastv = i.imm;
    end else begin
      va = mreg[i.ra];
      vb = mreg[i.rb];
      res = i.op ? va + vb : va - vb;
      chk({tag, "_a"}, bus.a, va);
      chk({tag, "_b"}, bus.b, vb);
      chk({tag, "_op"}, bus.op, i.op);
      chk({tag, "_exec_rdy"}, bus.in_ready, 0);
      chk({tag, "_exec_vld"}, bus.out_valid, 0);
      if (pre) drive(nx);
      @(negedge clk);
      mreg[i.rd] = res;
      chk_wb({tag, "_alu"}, i.rd, res);
      chk({tag, "_wb_rdy"}, bus.in_ready, 1);
      lastv = res;
      if (pre) chk_dbg({tag, "_pre_noeffect"}, nx.rd);
    end
    lastw = 1'b1;
    chk_dbg({tag, "_dbg"}, i.rd);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_vld"}, bus.out_valid, 0);
    chk({tag, "_z"},   bus.z, lastw ? (lastv == 0) : 0);
    chk({tag, "_n"},   bus.n, lastw ? lastv[WIDTH-1] : 0);
  endtask

  initial begin
    ins_t none, a1, a2, r;
    none = mk(1, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0; bus.in_ld = 1'b0; bus.in_op = 1'b0;
    bus.in_rd = '0; bus.in_ra = '0; bus.in_rb = '0; bus.in_imm = '0; bus.dbg_addr = '0;
    foreach (mreg[k]) mreg[k] = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_a", bus.a, 0);
    chk("rst_b", bus.b, 0);
    chk("rst_op", bus.op, 1);
    chk("rst_outrd", bus.out_rd, 0);
    chk("rst_outdata", bus.out_data, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_n", bus.n, 0);
    for (int k = 0; k < 8; k++) chk_dbg("rst_dbg", k[AW-1:0]);

    send("ld_r1", mk(1, 0, 1, 0, 0, 16'h0005), 0, none);
    send("ld_r2", mk(1, 0, 2, 0, 0, 16'h0003), 0, none);
    idle_chk("idle0");
    send("add_r3", mk(0, 1, 3, 1, 2, 0), 0, none);
    send("sub_r4", mk(0, 0, 4, 2, 1, 0), 0, none);
    send("sub_r5", mk(0, 0, 5, 1, 1, 0), 0, none);
    idle_chk("idle_z");
    send("ld_r6", mk(1, 0, 6, 0, 0, 16'hFFFF), 0, none);
    send("wrap_r6", mk(0, 1, 6, 6, 1, 0), 0, none);

    // back-to-back with instruction held through EXEC
    a1 = mk(0, 1, 1, 1, 1, 0);
    a2 = mk(0, 1, 2, 1, 1, 0);
    send("b2b_1", a1, 1, a2);
    send("b2b_2", a2, 0, none);
    chk("b2b_r2", mreg[2], 16'h0014);

    send("ld_r0", mk(1, 0, 0, 0, 0, 16'h0007), 0, none);
    send("raw_r3", mk(0, 1, 3, 0, 0, 0), 0, none);

    // load presented during EXEC must wait for IDLE
    a2 = mk(1, 0, 5, 0, 0, 16'hBEEF);
    send("exec_ign", mk(0, 1, 4, 1, 2, 0), 1, a2);
    send("exec_ld", a2, 0, none);

    // reset in the middle of EXEC
    send("ld_r7", mk(1, 0, 7, 0, 0, 16'h1234), 0, none);
    drive(mk(0, 1, 7, 7, 1, 0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rstx_exec_rdy", bus.in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    foreach (mreg[k]) mreg[k] = '0;
    lastw = 1'b0;
    chk("rstx_rdy", bus.in_ready, 1);
    chk("rstx_vld", bus.out_valid, 0);
    chk("rstx_a", bus.a, 0);
    chk("rstx_op", bus.op, 1);
    @(negedge clk);
    chk("rstx_vld2", bus.out_valid, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstx_post_vld", bus.out_valid, 0);
      chk("rstx_post_rdy", bus.in_ready, 1);
    end
    chk_dbg("rstx_r7", 3'd7);
    chk_dbg("rstx_r1", 3'd1);

    // random stream
    for (int t = 0; t < 120; t++) begin
      r = mk($urandom_range(0, 2) == 0, $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 5) == 0) r.imm = '0;
      if ($urandom_range(0, 5) == 0) r.imm = 16'h8000;
      if (!r.ld && $urandom_range(0, 3) == 0) begin
        a2 = mk($urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
        send("rnd_pre", r, 1, a2);
        send("rnd_nx", a2, 0, none);
      end else begin
        send("rnd", r, 0, none);
      end
      if ($urandom_range(0, 3) == 0) idle_chk("rnd_idle");
    end
    for (int k = 0; k < 8; k++) chk_dbg("final_dbg", k[AW-1:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
